// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store controller between the core data-memory port and a
// word-organised RAM / peripheral bus.
//
// Each byte-addressed request becomes one word-aligned, byte-enabled
// transaction on a req/ack handshake. The core sees stall_o for the whole
// access. Loads come back aligned to bit 0 and sign- or zero-extended.
// Misaligned, out-of-window, malformed and timed-out accesses pulse err_o.
//
// Ports:
//   clk_i, reset_i          clock (rising edge), synchronous active-high reset
//   addr_i, wdata_i         byte address and right-aligned store data from core
//   memwrite_i, memread_i   store / load request strobes
//   sign_mask_i             [3] signed load, [2:0] size (001 byte, 011 half, 111 word)
//   stall_o                 high while a request is accepted or outstanding
//   rdata_o, rvalid_o       load result and its one-cycle valid pulse
//   err_o                   one-cycle pulse on a rejected or aborted access
//   mem_req_o .. mem_wdata_o  memory-side transaction (held stable while busy)
//   mem_rdata_i, mem_ack_i  memory-side read word and completion

module data_mem_ctrl #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int          TIMEOUT   = 15
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              memwrite_i,
  input  logic              memread_i,
  input  logic [3:0]        sign_mask_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              rvalid_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i
);

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, RESP = 2'b10} state_t;

  // Last BUSY cycle index before the access is abandoned (counter starts at 0).
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t             state_r;
  state_t             state_s;
  logic [1:0]         off_r;
  logic [3:0]         mask_r;
  logic [7:0]         cnt_r;
  logic               mem_req_r;
  logic               mem_we_r;
  logic [3:0]         mem_be_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [31:0]        mem_wdata_r;
  logic [31:0]        rdata_r;
  logic               rvalid_r;
  logic               err_r;

  logic               req_s;
  logic               size_ok_s;
  logic               win_ok_s;
  logic               align_ok_s;
  logic               legal_s;

  // Byte-lane enables for a given size and byte offset.
  function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'b001:  lane_be = 4'b0001 << off;
      3'b011:  lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Replicate store data across lanes so the enabled lane always carries it.
  function automatic logic [31:0] lane_data(input logic [2:0] size, input logic [31:0] wd);
    case (size)
      3'b001:  lane_data = {4{wd[7:0]}};
      3'b011:  lane_data = {2{wd[15:0]}};
      default: lane_data = wd;
    endcase
  endfunction

  // Shift the addressed bytes down to bit 0, then mask and extend to 32 bits.
  function automatic logic [31:0] align_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [3:0] mask);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (mask[2:0])
      3'b001:  align_load = mask[3] ? {{24{sh[7]}}, sh[7:0]} : {24'h00_0000, sh[7:0]};
      3'b011:  align_load = mask[3] ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
      default: align_load = sh;
    endcase
  endfunction

  assign req_s = memread_i | memwrite_i;

  // Request legality: size encoding, address window and natural alignment.
  always_comb begin
    size_ok_s  = 1'b0;
    align_ok_s = 1'b0;
    case (sign_mask_i[2:0])
      3'b001: begin size_ok_s = 1'b1; align_ok_s = 1'b1; end
      3'b011: begin size_ok_s = 1'b1; align_ok_s = ~addr_i[0]; end
      3'b111: begin size_ok_s = 1'b1; align_ok_s = (addr_i[1:0] == 2'b00); end
      default: begin size_ok_s = 1'b0; align_ok_s = 1'b0; end
    endcase
    win_ok_s = (addr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    legal_s  = ~(memread_i & memwrite_i) & size_ok_s & win_ok_s & align_ok_s;
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; an ack in the timeout cycle takes priority.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (legal_s) state_s = BUSY;
          else         state_s = RESP;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (mem_ack_i)             state_s = RESP;
        else if (cnt_r == TO_LAST) state_s = RESP;
        else                       state_s = BUSY;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath: latch the transaction, run the timeout and produce the response.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      off_r       <= 2'b00;
      mask_r      <= 4'b0000;
      cnt_r       <= 8'd0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= 4'b0000;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'h0000_0000;
      rdata_r     <= 32'h0000_0000;
      rvalid_r    <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_s && legal_s) begin
            off_r       <= addr_i[1:0];
            mask_r      <= sign_mask_i;
            cnt_r       <= 8'd0;
            mem_req_r   <= 1'b1;
            mem_we_r    <= memwrite_i;
            mem_be_r    <= lane_be(sign_mask_i[2:0], addr_i[1:0]);
            mem_addr_r  <= addr_i[ADDR_W+1:2];
            mem_wdata_r <= lane_data(sign_mask_i[2:0], wdata_i);
          end else if (req_s) begin
            err_r   <= 1'b1;
            rdata_r <= 32'h0000_0000;
          end
        end
        BUSY: begin
          cnt_r <= cnt_r + 8'd1;
          if (mem_ack_i) begin
            mem_req_r <= 1'b0;
            if (!mem_we_r) begin
              rvalid_r <= 1'b1;
              rdata_r  <= align_load(mem_rdata_i, off_r, mask_r);
            end
          end else if (cnt_r == TO_LAST) begin
            mem_req_r <= 1'b0;
            err_r     <= 1'b1;
            rdata_r   <= 32'h0000_0000;
          end
        end
        default: begin
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // stall is combinational in IDLE so the core freezes in the request cycle.
  assign stall_o     = (state_r != IDLE) | req_s;
  assign rdata_o     = rdata_r;
  assign rvalid_o    = rvalid_r;
  assign err_o       = err_r;
  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_be_o    = mem_be_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;

endmodule
